// File: rtl/clkdiv_seq_pkg.sv
// Shared types for the CLKDIV power-up/recovery sequencer: FSM states, the registered output
// bundle, its reset value and the state-to-output decode.
package clkdiv_seq_pkg;

  typedef enum logic [2:0] {
    StWaitLock,
    StHold,
    StSettle,
    StRun,
    StCalibPulse,
    StCalibGap
  } state_e;

  typedef struct packed {
    logic clkdiv_resetn;
    logic clkdiv_calib;
    logic div_rst;
    logic ready;
    logic calib_ack;
  } seq_out_t;

  localparam seq_out_t OutRst = '{
    clkdiv_resetn: 1'b0,
    clkdiv_calib:  1'b0,
    div_rst:       1'b1,
    ready:         1'b0,
    calib_ack:     1'b0
  };

  function automatic seq_out_t state_outputs(state_e st);
    seq_out_t o;
    o = OutRst;
    case (st)
      StSettle: o.clkdiv_resetn = 1'b1;
      StRun, StCalibGap: begin
        o.clkdiv_resetn = 1'b1;
        o.div_rst       = 1'b0;
        o.ready         = 1'b1;
      end
      StCalibPulse: begin
        o.clkdiv_resetn = 1'b1;
        o.div_rst       = 1'b0;
        o.ready         = 1'b1;
        o.clkdiv_calib  = 1'b1;
        o.calib_ack     = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic int unsigned max4(int unsigned a, int unsigned b, int unsigned c,
                                       int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a terminal-count flag, shared by every timed sequencer state.
module seq_timer
  import clkdiv_seq_pkg::*;
#(
  parameter int unsigned CntW     = 8,
  parameter int unsigned ResetVal = 0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            en_i,
  output logic            done_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= CntW'(ResetVal);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/clkdiv_sequencer.sv
// Power-up/recovery sequencer for CLKDIV: qualifies PLL lock, sequences RESETN and the divided
// domain reset, then issues single-cycle CALIB pulses through a req/ack handshake.
module clkdiv_sequencer
  import clkdiv_seq_pkg::*;
#(
  parameter int unsigned LOCK_FILTER   = 64,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 32,
  parameter int unsigned CALIB_GAP     = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pll_lock_i,
  input  logic soft_rst_i,
  input  logic calib_req_i,
  output logic calib_ack_o,
  output logic clkdiv_resetn_o,
  output logic clkdiv_calib_o,
  output logic div_rst_o,
  output logic ready_o
);

  if ((LOCK_FILTER < 1) || (HOLD_CYCLES < 1) || (SETTLE_CYCLES < 1) || (CALIB_GAP < 1) ||
      ((64'd1 << CNT_W) <= 64'(max4(LOCK_FILTER, HOLD_CYCLES, SETTLE_CYCLES, CALIB_GAP))))
  begin : g_param_check
    $error("clkdiv_sequencer: timing parameter zero or too wide for CNT_W");
  end

  // Timers count down from P-1 so done marks the last cycle of each timed phase.
  localparam logic [CNT_W-1:0] LockLoad   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] HoldLoad   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLoad    = CNT_W'(CALIB_GAP - 1);

  state_e           state_q, state_d;
  seq_out_t         out_q;
  logic             tmr_load, tmr_en, tmr_done;
  logic [CNT_W-1:0] tmr_val;

  seq_timer #(
    .CntW     (CNT_W),
    .ResetVal (LOCK_FILTER - 1)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = LockLoad;
    unique case (state_q)
      StWaitLock: begin
        if (!pll_lock_i) begin
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          state_d  = StHold;
          tmr_load = 1'b1;
          tmr_val  = HoldLoad;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StHold: begin
        if (tmr_done) begin
          state_d  = StSettle;
          tmr_load = 1'b1;
          tmr_val  = SettleLoad;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StSettle: begin
        if (tmr_done) state_d = StRun;
        else          tmr_en  = 1'b1;
      end
      StRun: begin
        if (calib_req_i) state_d = StCalibPulse;
      end
      StCalibPulse: begin
        state_d  = StCalibGap;
        tmr_load = 1'b1;
        tmr_val  = GapLoad;
      end
      StCalibGap: begin
        if (tmr_done) state_d = StRun;
        else          tmr_en  = 1'b1;
      end
      default: state_d = StWaitLock;
    endcase

    // Aborts override everything, so a request in the same cycle is never acknowledged.
    if (soft_rst_i || ((state_q != StWaitLock) && !pll_lock_i)) begin
      state_d  = StWaitLock;
      tmr_load = 1'b1;
      tmr_val  = LockLoad;
      tmr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StWaitLock;
      out_q   <= OutRst;
    end else begin
      state_q <= state_d;
      out_q   <= state_outputs(state_d);
    end
  end

  assign clkdiv_resetn_o = out_q.clkdiv_resetn;
  assign clkdiv_calib_o  = out_q.clkdiv_calib;
  assign div_rst_o       = out_q.div_rst;
  assign ready_o         = out_q.ready;
  assign calib_ack_o     = out_q.calib_ack;

endmodule

// File: tb/tb_clkdiv_sequencer.sv
// Self-checking bench for clkdiv_sequencer: directed scenarios plus randomized traffic, checked
// against a lock-streak / elapsed-time reference model.
module tb_clkdiv_sequencer;

  localparam int LF = 64;
  localparam int H  = 16;
  localparam int S  = 32;
  localparam int CG = 8;
  localparam logic [4:0] RstVec = 5'b00100; // {resetn, calib, div_rst, ready, ack}

  logic clk = 1'b0;
  logic rst, pll_lock, soft_rst, calib_req;
  logic calib_ack, clkdiv_resetn, clkdiv_calib, div_rst, ready;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: lock streak before qualification, elapsed cycles after it.
  int streak  = 0;
  int since_q = -1;
  bit m_pulse = 1'b0;
  int cool    = 0;

  always #5 clk = ~clk;

  clkdiv_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pll_lock_i      (pll_lock),
    .soft_rst_i      (soft_rst),
    .calib_req_i     (calib_req),
    .calib_ack_o     (calib_ack),
    .clkdiv_resetn_o (clkdiv_resetn),
    .clkdiv_calib_o  (clkdiv_calib),
    .div_rst_o       (div_rst),
    .ready_o         (ready)
  );

  function automatic logic [4:0] dut_vec();
    return {clkdiv_resetn, clkdiv_calib, div_rst, ready, calib_ack};
  endfunction

  function automatic logic [4:0] exp_vec();
    logic rn, run;
    rn  = (since_q >= H);
    run = (since_q >= H + S);
    return {rn, m_pulse, ~run, run, m_pulse};
  endfunction

  // Advance one clock edge, update the model from the inputs sampled there, settle 1 time unit.
  task automatic cycle();
    bit running;
    @(posedge clk);
    running = (since_q >= H + S);
    if (rst || soft_rst || (since_q >= 0 && !pll_lock)) begin
      streak  = 0;
      since_q = -1;
      m_pulse = 1'b0;
      cool    = 0;
    end else if (since_q < 0) begin
      streak = pll_lock ? streak + 1 : 0;
      if (streak == LF) begin
        since_q = 0;
        streak  = 0;
      end
    end else begin
      if (m_pulse) begin
        m_pulse = 1'b0;
        cool    = CG;
      end else if (cool > 0) begin
        cool--;
      end else if (running && calib_req) begin
        m_pulse = 1'b1;
      end
      if (since_q <= H + S) since_q++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_lock = 1'b0; soft_rst = 1'b0; calib_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== RstVec) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got %b want %b", i, dut_vec(), RstVec);
      end
    end
  endtask

  task automatic test_powerup();
    int rise, fall;
    rise = -1; fall = -1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    pll_lock = 1'b1;
    for (int i = 1; i <= 150; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL powerup cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (rise < 0 && clkdiv_resetn === 1'b1) rise = i;
      if (fall < 0 && div_rst === 1'b0) begin
        fall = i;
        n_cmp++;
        if (ready !== 1'b1) begin
          n_bad++;
          $display("FAIL powerup_ready: got %b want 1", ready);
        end
      end
    end
    n_cmp++;
    if (rise != LF + H) begin
      n_bad++;
      $display("FAIL powerup_resetn_rise: got %0d want %0d", rise, LF + H);
    end
    n_cmp++;
    if (fall != LF + H + S) begin
      n_bad++;
      $display("FAIL powerup_divrst_fall: got %0d want %0d", fall, LF + H + S);
    end
  endtask

  task automatic test_lock_glitch();
    int rise;
    rise = -1;
    soft_rst = 1'b1;
    cycle();
    soft_rst = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      pll_lock = (i != 41);
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL glitch cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (rise < 0 && clkdiv_resetn === 1'b1) rise = i;
    end
    n_cmp++;
    if (rise != LF + H + 41) begin
      n_bad++;
      $display("FAIL glitch_resetn_rise: got %0d want %0d", rise, LF + H + 41);
    end
  endtask

  task automatic test_calib();
    int acks, first, second;
    acks = 0; first = -1; second = -1;
    calib_req = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i == 21) calib_req = 1'b0;
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL calib cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (calib_ack === 1'b1) begin
        acks++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    n_cmp++;
    if (acks != 2) begin
      n_bad++;
      $display("FAIL calib_ack_count: got %0d want 2", acks);
    end
    n_cmp++;
    if (second - first != 1 + CG + 1) begin
      n_bad++;
      $display("FAIL calib_spacing: got %0d want %0d", second - first, CG + 2);
    end
  endtask

  task automatic test_lock_loss_gap();
    int rise, fall, acks, waited;
    rise = -1; fall = -1; acks = 0; waited = 0;
    calib_req = 1'b1;
    while (calib_ack !== 1'b1 && waited < 30) begin
      cycle();
      waited++;
    end
    n_cmp++;
    if (waited >= 30) begin
      n_bad++;
      $display("FAIL gap_wait_ack: got no ack within %0d cycles, want one", waited);
    end
    calib_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    calib_req = 1'b1;
    pll_lock  = 1'b0;
    cycle();
    n_cmp++;
    if (dut_vec() !== RstVec) begin
      n_bad++;
      $display("FAIL gap_lock_loss: got %b want %b", dut_vec(), RstVec);
    end
    calib_req = 1'b0;
    pll_lock  = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL gap_recover cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (calib_ack === 1'b1) acks++;
      if (rise < 0 && clkdiv_resetn === 1'b1) rise = i;
      if (fall < 0 && div_rst === 1'b0) fall = i;
    end
    n_cmp++;
    if (rise != LF + H || fall != LF + H + S || acks != 0) begin
      n_bad++;
      $display("FAIL gap_resequence: got rise %0d fall %0d acks %0d want %0d %0d 0",
               rise, fall, acks, LF + H, LF + H + S);
    end
  endtask

  task automatic test_soft_and_lock();
    int rise;
    rise = -1;
    soft_rst = 1'b1; pll_lock = 1'b0; calib_req = 1'b1;
    cycle();
    n_cmp++;
    if (dut_vec() !== RstVec) begin
      n_bad++;
      $display("FAIL soft_lock_abort: got %b want %b", dut_vec(), RstVec);
    end
    calib_req = 1'b0;
    pll_lock  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== RstVec) begin
        n_bad++;
        $display("FAIL soft_held cyc %0d: got %b want %b", i, dut_vec(), RstVec);
      end
    end
    soft_rst = 1'b0;
    for (int i = 1; i <= 130; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL soft_recover cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (rise < 0 && clkdiv_resetn === 1'b1) rise = i;
    end
    n_cmp++;
    if (rise != LF + H) begin
      n_bad++;
      $display("FAIL soft_resetn_rise: got %0d want %0d", rise, LF + H);
    end
  endtask

  task automatic test_settle_rst();
    int rise, fall, waited;
    rise = -1; fall = -1; waited = 0;
    soft_rst = 1'b1;
    cycle();
    soft_rst = 1'b0;
    while (clkdiv_resetn !== 1'b1 && waited < 200) begin
      cycle();
      waited++;
    end
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b1;
    cycle();
    n_cmp++;
    if (dut_vec() !== RstVec) begin
      n_bad++;
      $display("FAIL settle_rst: got %b want %b", dut_vec(), RstVec);
    end
    rst = 1'b0;
    for (int i = 1; i <= 130; i++) begin
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL settle_recover cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (rise < 0 && clkdiv_resetn === 1'b1) rise = i;
      if (fall < 0 && div_rst === 1'b0) fall = i;
    end
    n_cmp++;
    if (rise != LF + H || fall != LF + H + S) begin
      n_bad++;
      $display("FAIL settle_resequence: got rise %0d fall %0d want %0d %0d",
               rise, fall, LF + H, LF + H + S);
    end
  endtask

  task automatic test_random();
    logic prev_ack;
    prev_ack = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      pll_lock = ($urandom_range(0, 399) != 0);
      soft_rst = ($urandom_range(0, 599) == 0);
      rst      = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 5) == 0) calib_req = ~calib_req;
      cycle();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      n_cmp++;
      if (prev_ack === 1'b1 && calib_ack === 1'b1) begin
        n_bad++;
        $display("FAIL random_ack_twice cyc %0d: got back-to-back ack want single", i);
      end
      prev_ack = calib_ack;
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_lock_glitch();
    test_calib();
    test_lock_loss_gap();
    test_soft_and_lock();
    test_settle_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clkdiv_sequencer.md
Name: clkdiv_sequencer

Overview:
- Power-up and recovery sequencer for the GW1NR-9 CLKDIV primitive (DIV_MODE 2).
- Runs on the fast source clock (the clock fed to HCLKIN). It qualifies PLL lock, drives CLKDIV RESETN, and waits for the divided clock to settle.
- It then releases a reset for the divided-clock domain and issues CALIB phase-adjust pulses on request through a req/ack handshake.
- Sits between the PLL wrapper and the CLKDIV wrapper in the clock/reset top.

Parameters:
- LOCK_FILTER, 64: consecutive cycles pll_lock must be high before leaving WAIT_LOCK (must be ≥1).
- HOLD_CYCLES, 16: cycles clkdiv_resetn is held low after lock is qualified (must be ≥1).
- SETTLE_CYCLES, 32: cycles after clkdiv_resetn rises before div_rst is released (must be ≥1).
- CALIB_GAP, 8: minimum cycles between the end of one CALIB pulse and acceptance of the next request (must be ≥1).
- CNT_W, 8: shared counter width; must satisfy 2^CNT_W > max(LOCK_FILTER, HOLD_CYCLES, SETTLE_CYCLES, CALIB_GAP).

Ports:
- clk, input, 1: fast source clock, same net as the CLKDIV HCLKIN.
- rst, input, 1: synchronous, active-high reset.
- pll_lock, input, 1: PLL lock indicator; already synchronised to clk by the PLL wrapper.
- soft_rst, input, 1: one-or-more-cycle request to re-run the full sequence.
- calib_req, input, 1: request one CALIB pulse; level held until calib_ack.
- calib_ack, output, 1: single-cycle acknowledge when the CALIB pulse is issued.
- clkdiv_resetn, output, 1: drives CLKDIV RESETN.
- clkdiv_calib, output, 1: drives CLKDIV CALIB.
- div_rst, output, 1: active-high reset for the divided domain; registered; the consumer re-synchronises it.
- ready, output, 1: high only in RUN or CALIB states (clock stable, domain out of reset).

Behaviour:
- Reset values: state=WAIT_LOCK, cnt=0, clkdiv_resetn=0, clkdiv_calib=0, div_rst=1, ready=0, calib_ack=0.
- All outputs are registered. Every state transition takes effect on the clock edge after the condition is sampled.
- WAIT_LOCK:
  - cnt increments while pll_lock=1; cnt clears on any cycle pll_lock=0.
  - When cnt reaches LOCK_FILTER-1 with pll_lock=1 → HOLD, cnt=0.
- HOLD: clkdiv_resetn=0; after HOLD_CYCLES cycles → SETTLE, cnt=0, clkdiv_resetn=1.
- SETTLE: div_rst=1; after SETTLE_CYCLES cycles → RUN, div_rst=0, ready=1.
- RUN: when calib_req=1 → CALIB_PULSE, clkdiv_calib=1, calib_ack=1 (both asserted in the same cycle).
- CALIB_PULSE:
  - Lasts exactly one cycle: clkdiv_calib falls and calib_ack falls.
  - Then → CALIB_GAP state for CALIB_GAP cycles → RUN.
  - A calib_req still high on return to RUN starts a new pulse; there is no queuing beyond this level behaviour.
- Abort conditions, priority high to low: rst > soft_rst > loss of lock.
  - soft_rst=1 in any state: → WAIT_LOCK next edge, with reset-value outputs. soft_rst held high keeps the block in WAIT_LOCK with cnt=0.
  - pll_lock=0 in HOLD/SETTLE/RUN/CALIB_PULSE/CALIB_GAP: → WAIT_LOCK next edge, clkdiv_resetn=0, div_rst=1, ready=0, clkdiv_calib=0.
  - A pending calib_req is dropped without ack on abort; the requester must re-request after ready.
- calib_req in WAIT_LOCK/HOLD/SETTLE is ignored (no ack).
- A calib_req arriving simultaneously with lock loss or soft_rst is not acknowledged.
- Counter rules:
  - cnt compares against P-1 and never exceeds max(param)-1, so no wrap is possible with legal parameters.
  - Width is checked by an initial assertion.
- calib_ack is a one-cycle pulse per accepted request; it never fires in two consecutive cycles.

Decomposition:
- Package clkdiv_seq_pkg holds:
  - state enum: WAIT_LOCK, HOLD, SETTLE, RUN, CALIB_PULSE, CALIB_GAP;
  - a localparam for the reset-state output vector.
- A single sub-module, seq_timer, is natural: a loadable down-counter with a done flag, reused by every timed state. The FSM stays in clkdiv_sequencer.

Test Plan:
- Power-up: rst high 5 cycles, pll_lock=1 from cycle 10, default parameters.
  - clkdiv_resetn rises 64+16 cycles after lock.
  - div_rst falls 32 cycles later; ready=1 at that edge.
- Lock glitch: pll_lock low for 1 cycle at filter count 40 → filter restarts; clkdiv_resetn rise is delayed by 41 cycles versus the clean case.
- Calibration: in RUN, hold calib_req for 20 cycles.
  - clkdiv_calib pulses exactly 1 cycle each time, with calib_ack coincident.
  - Pulses are separated by 1+8 cycles.
  - Exactly 2 acks occur within the 20 cycles.
- Lock loss in CALIB_GAP: next edge gives clkdiv_resetn=0, div_rst=1, ready=0, no further ack; after lock returns, the full 64/16/32 sequence repeats.
- soft_rst and lock loss asserted in the same RUN cycle → WAIT_LOCK, all reset-value outputs.
  - With soft_rst held 10 cycles, the lock filter count starts only after soft_rst drops.
- Mid-SETTLE rst pulse: all outputs return to reset values on the next edge; the sequence restarts from WAIT_LOCK.
